// File: rtl/fifo_drain_scheduler.sv
// fifo_drain_scheduler
//   Core-clock scheduler that drains NUM_CH sample FIFOs into one shared
//   valid/ready sink. Picks a non-empty, unmasked channel round-robin, reads one
//   word at a time (FIFO read latency 1), and presents each word with its
//   channel tag. A grant lasts at most BURST_LEN words.
//
// Ports
//   clk2       core clock, all state on posedge
//   reset_n    asynchronous active-low reset
//   enable     allows new bursts; dropping it ends the current burst early
//   ch_mask    per-channel eligibility (sampled only when choosing a grant)
//   ch_empty   per-channel FIFO empty flags
//   ch_rd_en   per-channel FIFO read enable, one-hot or zero
//   ch_data    FIFO output words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_data   captured word
//   out_ch     channel the word came from
//   out_last   last word of the current burst
//   out_valid  word valid, held until out_ready
//   out_ready  sink accepts the word
//   busy       scheduler is in a burst (state != IDLE)
module fifo_drain_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk2,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [NUM_CH-1:0]            ch_empty,
  output logic [NUM_CH-1:0]            ch_rd_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int WC_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  state_t                            state, state_nx;
  logic [CH_W-1:0]                   rr_ptr, grant, pick;
  logic                              pick_ok;
  logic [WC_W-1:0]                   word_cnt;
  logic [NUM_CH-1:0]                 req, lane_sel, lane_empty;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] ch_words, lane_data;
  logic [DATA_WIDTH-1:0]             grant_data;
  logic                              grant_empty;
  logic                              rd_cycle;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  assign req      = ~ch_empty & ch_mask;
  assign ch_words = ch_data;

  // Round-robin pick: scan offsets high to low so the nearest request to
  // rr_ptr is the last (winning) assignment.
  always_comb begin
    logic [CH_W-1:0] idx;
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (req[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  // Per-channel lane: read strobe never fires on an empty FIFO, and the
  // selected lane's data/empty are OR-reduced into the granted view.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign lane_sel[i]   = (grant == CH_W'(i));
    assign ch_rd_en[i]   = lane_sel[i] & rd_cycle & ~ch_empty[i];
    assign lane_empty[i] = lane_sel[i] & ch_empty[i];
    assign lane_data[i]  = lane_sel[i] ? ch_words[i] : '0;
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) grant_data = grant_data | lane_data[i];
  end

  assign grant_empty = |lane_empty;

  // State register
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable && pick_ok) state_nx = RD;
      // Flag went empty between grant and read: abandon without a word.
      RD:      state_nx = grant_empty ? IDLE : CAP;
      CAP:     state_nx = OUT;
      OUT:     if (out_ready) state_nx = out_last ? IDLE : RD;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy     = (state != IDLE);
    rd_cycle = (state == RD);
  end

  // Grant, pointer, counter and output word registers
  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      grant     <= '0;
      word_cnt  <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable && pick_ok) begin
          grant    <= pick;
          word_cnt <= '0;
        end
        RD: if (grant_empty) rr_ptr <= next_ch(grant);
        CAP: begin
          out_data  <= grant_data;
          out_ch    <= grant;
          // End the burst at the length cap, when the FIFO just ran dry,
          // or when enable was pulled.
          out_last  <= (word_cnt == WC_W'(BURST_LEN - 1)) || grant_empty || !enable;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          word_cnt  <= word_cnt + 1'b1;
          if (out_last) rr_ptr <= next_ch(grant);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Bench for fifo_drain_scheduler: behavioural FIFOs feed the DUT, a monitor
// collects accepted words, and a transaction-level model predicts the word
// stream from queue contents, mask and burst rules.
module tb_fifo_drain_scheduler;
  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int BL     = 4;
  localparam int CH_W   = 2;
  localparam int DEPTH  = 512;

  typedef logic [CH_W+DW:0] rec_t;  // {ch, last, data}

  logic                 clk2 = 1'b0;
  logic                 reset_n, enable, out_ready, out_last, out_valid, busy;
  logic [NUM_CH-1:0]    ch_mask, ch_empty, ch_rd_en;
  logic [NUM_CH*DW-1:0] ch_data;
  logic [DW-1:0]        out_data;
  logic [CH_W-1:0]      out_ch;

  fifo_drain_scheduler #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk2(clk2), .reset_n(reset_n), .enable(enable), .ch_mask(ch_mask),
    .ch_empty(ch_empty), .ch_rd_en(ch_rd_en), .ch_data(ch_data),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk2 = ~clk2;

  // ---------------- behavioural FIFOs (read latency 1) ----------------
  logic [DW-1:0] mem [NUM_CH][DEPTH];
  logic [DW-1:0] dout [NUM_CH];
  int            rp [NUM_CH] = '{default: 0};
  int            wp [NUM_CH] = '{default: 0};
  bit            flush = 1'b0;

  always @(posedge clk2) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (flush) rp[i] <= wp[i];
      else if (ch_rd_en[i] && rp[i] != wp[i]) begin
        dout[i] <= mem[i][rp[i]];
        rp[i]   <= rp[i] + 1;
      end
    end
  end

  always_comb begin
    ch_empty = '0;
    ch_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_empty[i]         = (rp[i] == wp[i]);
      ch_data[i*DW +: DW] = dout[i];
    end
  end

  // ---------------- sink ready driver ----------------
  int ready_pct = 100;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk2); #2;
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // ---------------- monitor ----------------
  rec_t got[$];
  int   rd_bad = 0, stab_bad = 0;
  int   rd_cnt [NUM_CH] = '{default: 0};
  logic pv = 1'b0, pr = 1'b0;
  rec_t prec = '0;

  function automatic int rd_viol(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] emp,
                                 input logic [NUM_CH-1:0] m);
    int n = $onehot0(en) ? 0 : 1;
    for (int i = 0; i < NUM_CH; i++) if (en[i] && (emp[i] || !m[i])) n++;
    return n;
  endfunction

  always @(negedge clk2) begin
    if (out_valid && out_ready) got.push_back({out_ch, out_last, out_data});
    rd_bad <= rd_bad + rd_viol(ch_rd_en, ch_empty, ch_mask);
    for (int i = 0; i < NUM_CH; i++) if (ch_rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
    if (!reset_n) pv <= 1'b0;
    else begin
      if (pv && !pr && (!out_valid || {out_ch, out_last, out_data} !== prec)) stab_bad <= stab_bad + 1;
      pv   <= out_valid;
      pr   <= out_ready;
      prec <= {out_ch, out_last, out_data};
    end
  end

  // ---------------- reference model ----------------
  // Round-robin from channel 0; each burst takes up to BL words from the
  // chosen queue and ends early when that queue runs dry.
  rec_t exp_q[$];
  task automatic build_exp(input logic [NUM_CH-1:0] m);
    int p [NUM_CH];
    int ptr, g, c;
    bit fnd, last;
    exp_q.delete();
    ptr = 0;
    for (int i = 0; i < NUM_CH; i++) p[i] = rp[i];
    forever begin
      fnd = 1'b0; g = 0;
      for (int off = 0; off < NUM_CH; off++) begin
        c = (ptr + off) % NUM_CH;
        if (!fnd && m[c] && p[c] < wp[c]) begin fnd = 1'b1; g = c; end
      end
      if (!fnd) break;
      for (int n = 1; n <= BL; n++) begin
        last = (n == BL) || (p[g] + 1 == wp[g]);
        exp_q.push_back({CH_W'(g), last, mem[g][p[g]]});
        p[g]++;
        if (last) break;
      end
      ptr = (g + 1) % NUM_CH;
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  int n_cmp = 0, n_fail = 0;

  task automatic push(input int c, input logic [DW-1:0] d);
    mem[c][wp[c]] = d;
    wp[c] = wp[c] + 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; ch_mask = '1; ready_pct = 100; flush = 1'b1;
    repeat (2) @(posedge clk2);
    #1; flush = 1'b0; reset_n = 1'b1;
  endtask

  task automatic wait_words(input int n, input int maxc);
    int c = 0;
    while (got.size() < n && c < maxc) begin @(negedge clk2); #1; c++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; ch_mask = '1; flush = 1'b1;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ch_rd_en !== '0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", ch_rd_en); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    n_cmp++; if (out_ch !== '0) begin n_fail++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
    repeat (2) @(posedge clk2);
    #1; flush = 1'b0; reset_n = 1'b1;
    repeat (3) @(posedge clk2); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_burst();
    int base, c, idle;
    rec_t a;
    do_reset();
    for (int k = 0; k < 6; k++) push(0, 8'($urandom));
    build_exp(4'b1111);
    base = got.size();
    @(negedge clk2); enable = 1'b1; c = 0;
    while (!out_valid && c < 20) begin @(posedge clk2); #1; c++; end
    n_cmp++; if (c !== 3) begin n_fail++; $display("FAIL burst_latency: got %0d want 3", c); end
    idle = 0; c = 0;
    while (c < 100) begin
      @(negedge clk2); #1; c++;
      if (got.size() >= base + 6) break;
      if (!busy) idle++;
    end
    n_cmp++; if (idle !== 1) begin n_fail++; $display("FAIL burst_idle_gap: got %0d want 1", idle); end
    n_cmp++; if (got.size() !== base + 6) begin n_fail++; $display("FAIL burst_count: got %0d want %0d", got.size() - base, 6); end
    for (int k = 0; k < exp_q.size(); k++) begin
      a = (base + k < got.size()) ? got[base + k] : 'x;
      n_cmp++; if (a !== exp_q[k]) begin n_fail++; $display("FAIL burst_word%0d: got %0h want %0h", k, a, exp_q[k]); end
    end
  endtask

  task automatic test_round_robin();
    int base, rb;
    rec_t a;
    do_reset();
    for (int ch = 0; ch < NUM_CH; ch++) repeat (2) push(ch, 8'($urandom));
    build_exp(4'b1111);
    base = got.size(); rb = rd_bad;
    enable = 1'b1;
    wait_words(base + 8, 200);
    repeat (6) @(posedge clk2); #1;
    n_cmp++; if (got.size() !== base + 8) begin n_fail++; $display("FAIL rr_count: got %0d want 8", got.size() - base); end
    for (int k = 0; k < exp_q.size(); k++) begin
      a = (base + k < got.size()) ? got[base + k] : 'x;
      n_cmp++; if (a !== exp_q[k]) begin n_fail++; $display("FAIL rr_word%0d: got %0h want %0h", k, a, exp_q[k]); end
    end
    n_cmp++; if (rd_bad !== rb) begin n_fail++; $display("FAIL rr_rd_en_rule: got %0d want 0", rd_bad - rb); end
  endtask

  task automatic test_stall();
    int base, c, r1, sb;
    logic [DW-1:0] w;
    rec_t a;
    do_reset();
    ready_pct = 0;
    w = 8'($urandom);
    push(1, w);
    r1 = rd_cnt[1]; base = got.size(); sb = stab_bad;
    enable = 1'b1; c = 0;
    while (!out_valid && c < 20) begin @(posedge clk2); #1; c++; end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== w) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%0h want v=1 d=%0h", k, out_valid, out_data, w);
      end
      @(posedge clk2); #1;
    end
    ready_pct = 100;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_6th: got %b want 1", out_valid); end
    @(posedge clk2); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", out_valid); end
    repeat (5) @(posedge clk2); #1;
    n_cmp++; if (rd_cnt[1] - r1 !== 1) begin n_fail++; $display("FAIL stall_rd_pulses: got %0d want 1", rd_cnt[1] - r1); end
    n_cmp++; if (got.size() !== base + 1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", got.size() - base); end
    a = (base < got.size()) ? got[base] : 'x;
    n_cmp++; if (a !== {2'd1, 1'b1, w}) begin n_fail++; $display("FAIL stall_word: got %0h want %0h", a, {2'd1, 1'b1, w}); end
    n_cmp++; if (stab_bad !== sb) begin n_fail++; $display("FAIL stall_stable: got %0d want 0", stab_bad - sb); end
  endtask

  task automatic test_mask();
    int base, r1, rb;
    rec_t a;
    do_reset();
    ch_mask = 4'b1101;
    for (int ch = 0; ch < NUM_CH; ch++) repeat ($urandom_range(1, 5)) push(ch, 8'($urandom));
    ready_pct = 60;
    build_exp(4'b1101);
    base = got.size(); r1 = rd_cnt[1]; rb = rd_bad;
    enable = 1'b1;
    wait_words(base + exp_q.size(), 1000);
    repeat (10) @(posedge clk2); #1;
    n_cmp++; if (got.size() !== base + exp_q.size()) begin n_fail++; $display("FAIL mask_count: got %0d want %0d", got.size() - base, exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      a = (base + k < got.size()) ? got[base + k] : 'x;
      n_cmp++; if (a !== exp_q[k]) begin n_fail++; $display("FAIL mask_word%0d: got %0h want %0h", k, a, exp_q[k]); end
    end
    n_cmp++; if (rd_cnt[1] !== r1) begin n_fail++; $display("FAIL mask_ch1_reads: got %0d want 0", rd_cnt[1] - r1); end
    n_cmp++; if (ch_empty[1] !== 1'b0) begin n_fail++; $display("FAIL mask_ch1_kept: got empty=%b want 0", ch_empty[1]); end
    n_cmp++; if (rd_bad !== rb) begin n_fail++; $display("FAIL mask_rd_en_rule: got %0d want 0", rd_bad - rb); end
  endtask

  task automatic test_enable_drop();
    int base, c;
    logic [DW-1:0] w [6];
    rec_t a, e;
    do_reset();
    for (int k = 0; k < 6; k++) begin w[k] = 8'($urandom); push(2, w[k]); end
    base = got.size();
    enable = 1'b1; c = 0;
    while (got.size() < base + 1 && c < 50) begin @(negedge clk2); #1; c++; end
    enable = 1'b0;
    repeat (20) @(posedge clk2); #1;
    n_cmp++; if (got.size() !== base + 2) begin n_fail++; $display("FAIL endrop_count: got %0d want 2", got.size() - base); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_idle: got %b want 0", busy); end
    enable = 1'b1;
    wait_words(base + 6, 200);
    repeat (4) @(posedge clk2); #1;
    for (int k = 0; k < 6; k++) begin
      e = {2'd2, (k == 1 || k == 5), w[k]};
      a = (base + k < got.size()) ? got[base + k] : 'x;
      n_cmp++; if (a !== e) begin n_fail++; $display("FAIL endrop_word%0d: got %0h want %0h", k, a, e); end
    end
  endtask

  task automatic test_reset_mid();
    int base, c, r2;
    logic [DW-1:0] w0, w3;
    rec_t a;
    do_reset();
    push(1, 8'($urandom));
    base = got.size();
    enable = 1'b1;
    wait_words(base + 1, 50);
    repeat (4) @(posedge clk2); #1;
    enable = 1'b0; ready_pct = 0;
    w0 = 8'($urandom); w3 = 8'($urandom);
    push(2, 8'($urandom)); push(3, w3); push(0, w0);
    r2 = rd_cnt[2];
    @(posedge clk2); #1;
    enable = 1'b1; c = 0;
    while (!out_valid && c < 20) begin @(posedge clk2); #1; c++; end
    n_cmp++; if (out_ch !== 2'd2 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_grant: got v=%b ch=%0d want v=1 ch=2", out_valid, out_ch); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (ch_rd_en !== '0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b want 0", ch_rd_en); end
    repeat (2) @(posedge clk2); #1;
    reset_n = 1'b1; ready_pct = 100;
    wait_words(base + 3, 100);
    repeat (4) @(posedge clk2); #1;
    a = (base + 1 < got.size()) ? got[base + 1] : 'x;
    n_cmp++; if (a !== {2'd0, 1'b1, w0}) begin n_fail++; $display("FAIL rstmid_first: got %0h want %0h", a, {2'd0, 1'b1, w0}); end
    a = (base + 2 < got.size()) ? got[base + 2] : 'x;
    n_cmp++; if (a !== {2'd3, 1'b1, w3}) begin n_fail++; $display("FAIL rstmid_second: got %0h want %0h", a, {2'd3, 1'b1, w3}); end
    n_cmp++; if (got.size() !== base + 3) begin n_fail++; $display("FAIL rstmid_count: got %0d want 3", got.size() - base); end
    n_cmp++; if (rd_cnt[2] - r2 !== 1) begin n_fail++; $display("FAIL rstmid_dropped_read: got %0d want 1", rd_cnt[2] - r2); end
  endtask

  task automatic test_random();
    int base, rb, sb;
    logic [NUM_CH-1:0] m;
    rec_t a;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      m = NUM_CH'($urandom_range(1, 15));
      ch_mask = m;
      for (int ch = 0; ch < NUM_CH; ch++) repeat ($urandom_range(0, 6)) push(ch, 8'($urandom));
      ready_pct = $urandom_range(25, 100);
      build_exp(m);
      base = got.size(); rb = rd_bad; sb = stab_bad;
      enable = 1'b1;
      wait_words(base + exp_q.size(), 3000);
      repeat (8) @(posedge clk2); #1;
      n_cmp++; if (got.size() !== base + exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", it, got.size() - base, exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
        a = (base + k < got.size()) ? got[base + k] : 'x;
        n_cmp++; if (a !== exp_q[k]) begin n_fail++; $display("FAIL rand%0d_word%0d: got %0h want %0h", it, k, a, exp_q[k]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_idle: got %b want 0", it, busy); end
      n_cmp++; if (rd_bad !== rb || stab_bad !== sb) begin
        n_fail++; $display("FAIL rand%0d_rules: got rd=%0d stab=%0d want 0 0", it, rd_bad - rb, stab_bad - sb);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; ch_mask = '1;
    test_reset();
    test_burst();
    test_round_robin();
    test_stall();
    test_mask();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
